// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative 32x32 multiply / divide unit owning the HI/LO registers.
// Optional build macro MULDIV_FAST_MULT_EN: single-cycle combinational MULT/MULTU.
module muldiv_unit (
   input  logic        clk,
   input  logic        reset,
   input  logic        startE,
   input  logic [1:0]  opE,
   input  logic [31:0] srcaE,
   input  logic [31:0] srcbE,
   input  logic        hiwrE,
   input  logic        lowrE,
   input  logic        flushE,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        busy
);

   localparam int unsigned W  = 32;
   localparam int unsigned CW = 5;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

   state_t          r_state;
   state_t          w_next;
   logic [CW-1:0]   r_cnt;
   logic [2*W-1:0]  r_acc;
   logic [W-1:0]    r_b;
   logic            r_neg_q;
   logic            r_neg_r;
   logic            r_is_div;
   logic            r_dz;

   logic            w_accept;
   logic            w_a_neg;
   logic            w_b_neg;
   logic [W-1:0]    w_a_mag;
   logic [W-1:0]    w_b_mag;
   logic [W:0]      w_mul_sum;
   logic [2*W-1:0]  w_mul_step;
   logic [2*W:0]    w_shift;
   logic [W:0]      w_trial;
   logic            w_qbit;
   logic [2*W-1:0]  w_div_step;
   logic [2*W-1:0]  w_prod_fix;
   logic [W-1:0]    w_quo;
   logic [W-1:0]    w_rem;
   logic [W-1:0]    w_res_hi;
   logic [W-1:0]    w_res_lo;
`ifdef MULDIV_FAST_MULT_EN
   logic [2*W-1:0]  w_fast_prod;
`endif

   assign busy     = (r_state != S_IDLE);
   assign w_accept = (r_state == S_IDLE) & startE & ~flushE;

   // Operand magnitudes and signs (opE[0]=0 selects signed)
   assign w_a_neg = ~opE[0] & srcaE[W-1];
   assign w_b_neg = ~opE[0] & srcbE[W-1];
   assign w_a_mag = w_a_neg ? (~srcaE + W'(1)) : srcaE;
   assign w_b_mag = w_b_neg ? (~srcbE + W'(1)) : srcbE;
`ifdef MULDIV_FAST_MULT_EN
   assign w_fast_prod = {{W{1'b0}}, w_a_mag} * {{W{1'b0}}, w_b_mag};
`endif

   // One shift-add multiply step: acc = {partial product, remaining multiplier}
   assign w_mul_sum  = {1'b0, r_acc[2*W-1:W]} + {1'b0, (r_acc[0] ? r_b : {W{1'b0}})};
   assign w_mul_step = {w_mul_sum, r_acc[W-1:1]};

   // One restoring divide step: acc = {remainder, dividend/quotient}
   assign w_shift    = {r_acc, 1'b0};
   assign w_trial    = w_shift[2*W:W] - {1'b0, r_b};
   assign w_qbit     = ~w_trial[W];
   assign w_div_step = {(w_qbit ? w_trial[W-1:0] : w_shift[2*W-1:W]), w_shift[W-1:1], w_qbit};

   // Sign correction applied during FIX
   assign w_prod_fix = r_neg_q ? (~r_acc + (2*W)'(1)) : r_acc;
   assign w_quo      = r_neg_q ? (~r_acc[W-1:0] + W'(1)) : r_acc[W-1:0];
   assign w_rem      = r_neg_r ? (~r_acc[2*W-1:W] + W'(1)) : r_acc[2*W-1:W];
   assign w_res_hi   = r_is_div ? w_rem : w_prod_fix[2*W-1:W];
   assign w_res_lo   = r_is_div ? (r_dz ? {W{1'b1}} : w_quo) : w_prod_fix[W-1:0];

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
`ifdef MULDIV_FAST_MULT_EN
               w_next = opE[1] ? S_RUN : S_FIX;
`else
               w_next = S_RUN;
`endif
            end
         end
         S_RUN:   if (r_cnt == CW'(31)) w_next = S_FIX;
         S_FIX:   w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Datapath, iteration counter and architectural HI/LO
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt    <= '0;
         r_acc    <= '0;
         r_b      <= '0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_is_div <= 1'b0;
         r_dz     <= 1'b0;
         hi       <= '0;
         lo       <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_b      <= w_b_mag;
                  r_neg_q  <= w_a_neg ^ w_b_neg;
                  r_neg_r  <= w_a_neg;
                  r_is_div <= opE[1];
                  r_dz     <= opE[1] & (srcbE == '0);
                  r_cnt    <= '0;
                  r_acc    <= {{W{1'b0}}, w_a_mag};
`ifdef MULDIV_FAST_MULT_EN
                  if (!opE[1]) r_acc <= w_fast_prod;
`endif
               end else if (!flushE) begin
                  if (hiwrE) hi <= srcaE;
                  if (lowrE) lo <= srcaE;
               end
            end
            S_RUN: begin
               r_acc <= r_is_div ? w_div_step : w_mul_step;
               r_cnt <= r_cnt + CW'(1);
            end
            S_FIX: begin
               hi <= w_res_hi;
               lo <= w_res_lo;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench for muldiv_unit (latency, results, hazards, reset).
module tb_muldiv_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        startE;
   logic [1:0]  opE;
   logic [31:0] srcaE;
   logic [31:0] srcbE;
   logic        hiwrE;
   logic        lowrE;
   logic        flushE;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        busy;

`ifdef MULDIV_FAST_MULT_EN
   localparam int MUL_LAT = 1;
`else
   localparam int MUL_LAT = 33;
`endif
   localparam int DIV_LAT = 33;

   int          n_checks = 0;
   int          n_pass   = 0;
   logic [63:0] sb_q[$];
   logic [31:0] exp_hi;
   logic [31:0] exp_lo;

   muldiv_unit dut (
      .clk    (clk),
      .reset  (reset),
      .startE (startE),
      .opE    (opE),
      .srcaE  (srcaE),
      .srcbE  (srcbE),
      .hiwrE  (hiwrE),
      .lowrE  (lowrE),
      .flushE (flushE),
      .hi     (hi),
      .lo     (lo),
      .busy   (busy)
   );

   always #5 clk = ~clk;

   // Reference model: returns {hi, lo}
   function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      longint      sa;
      longint      sb;
      logic [31:0] q;
      logic [31:0] r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (op)
         2'b00: return 64'(sa * sb);
         2'b01: return {32'b0, a} * {32'b0, b};
         2'b10: begin
            if (b == 32'h0) return {a, 32'hFFFFFFFF};
            q = 32'(sa / sb);
            r = 32'(sa % sb);
            return {r, q};
         end
         default: begin
            if (b == 32'h0) return {a, 32'hFFFFFFFF};
            return {a % b, a / b};
         end
      endcase
   endfunction

   function automatic int lat_of(input logic [1:0] op);
      return op[1] ? DIV_LAT : MUL_LAT;
   endfunction

   // Drive a start at the current (negedge) point; edge N is the next posedge
   task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      startE = 1'b1;
      opE    = op;
      srcaE  = a;
      srcbE  = b;
      sb_q.push_back(model(op, a, b));
      @(posedge clk); #1;
      n_checks++;
      if (busy !== 1'b1) $display("FAIL busy_rise: busy=%b required=1", busy);
      else n_pass++;
      @(negedge clk);
      startE = 1'b0;
      hiwrE  = 1'b0;
      lowrE  = 1'b0;
      srcaE  = $urandom;
      srcbE  = $urandom;
   endtask

   // Follow the operation to completion, checking latency, hold and the result
   task automatic wait_result(input string name, input int lat, input bit interfere);
      int          k;
      bit          timeout;
      logic [31:0] snap_hi;
      logic [31:0] snap_lo;
      logic [63:0] exp;
      k = 0;
      timeout = 1'b0;
      snap_hi = exp_hi;
      snap_lo = exp_lo;
      forever begin
         @(posedge clk); #1;
         k++;
         if (interfere && k == 3) begin
            startE = 1'b1; opE = 2'b10; hiwrE = 1'b1; lowrE = 1'b1;
            srcaE = 32'hDEADBEEF; srcbE = 32'h3;
         end
         if (interfere && k == 4) begin
            startE = 1'b0; hiwrE = 1'b0; lowrE = 1'b0;
         end
         if (k == lat - 1) begin
            snap_hi = hi;
            snap_lo = lo;
         end
         if (busy === 1'b0) break;
         if (k > 200) begin timeout = 1'b1; break; end
      end
      n_checks++;
      if (timeout || k != lat) $display("FAIL %s latency: edges=%0d timeout=%0b required=%0d", name, k, timeout, lat);
      else n_pass++;
      if (lat > 1) begin
         n_checks++;
         if (snap_hi !== exp_hi || snap_lo !== exp_lo)
            $display("FAIL %s hold: hi=%h lo=%h required hi=%h lo=%h", name, snap_hi, snap_lo, exp_hi, exp_lo);
         else n_pass++;
      end
      n_checks++;
      if (sb_q.size() == 0) begin
         $display("FAIL %s scoreboard: queue empty, required one entry", name);
      end else begin
         exp = sb_q.pop_front();
         if (hi !== exp[63:32] || lo !== exp[31:0])
            $display("FAIL %s result: hi=%h lo=%h required hi=%h lo=%h", name, hi, lo, exp[63:32], exp[31:0]);
         else n_pass++;
         exp_hi = exp[63:32];
         exp_lo = exp[31:0];
      end
   endtask

   task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      start_op(op, a, b);
      wait_result(name, lat_of(op), 1'b0);
   endtask

   task automatic test_reset();
      reset = 1'b1; startE = 1'b0; opE = 2'b00; srcaE = '0; srcbE = '0;
      hiwrE = 1'b0; lowrE = 1'b0; flushE = 1'b0;
      #2 reset = 1'b0;
      #1;
      exp_hi = '0;
      exp_lo = '0;
      n_checks++;
      if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0)
         $display("FAIL reset_state: busy=%b hi=%h lo=%h required 0/0/0", busy, hi, lo);
      else n_pass++;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_directed();
      run_op("mult_7_m3",     2'b00, 32'd7,        32'hFFFFFFFD);
      n_checks++;
      if (busy !== 1'b0) $display("FAIL mult_busy_after: busy=%b required=0", busy);
      else n_pass++;
      run_op("multu_max_2",   2'b01, 32'hFFFFFFFF, 32'd2);
      run_op("div_m7_2",      2'b10, 32'hFFFFFFF9, 32'd2);
      run_op("divu_100_0",    2'b11, 32'd100,      32'd0);
      run_op("div_m100_0",    2'b10, 32'hFFFFFF9C, 32'd0);
      run_op("div_min_m1",    2'b10, 32'h80000000, 32'hFFFFFFFF);
      run_op("mult_min_min",  2'b00, 32'h80000000, 32'h80000000);
   endtask

   task automatic test_random();
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      for (int i = 0; i < 8; i++) begin
         op = 2'($urandom_range(0, 3));
         a  = $urandom;
         b  = (i == 5) ? 32'h0 : ((i == 6) ? 32'($urandom_range(1, 9)) : $urandom);
         run_op($sformatf("rand%0d", i), op, a, b);
      end
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      start_op(2'b11, 32'h12345678, 32'h00000345);
      wait_result("busy_ignore", DIV_LAT, 1'b1);
      // Start together with mthi: start wins, the write is dropped
      @(negedge clk);
      hiwrE = 1'b1;
      start_op(2'b01, 32'h0BADF00D, 32'h00000010);
      wait_result("start_wins", lat_of(2'b01), 1'b0);
   endtask

   task automatic test_flush_mtlo();
      @(negedge clk);
      startE = 1'b1; flushE = 1'b1; hiwrE = 1'b1; lowrE = 1'b1; opE = 2'b10;
      srcaE = 32'h55AA55AA; srcbE = 32'h3;
      @(posedge clk); #1;
      n_checks++;
      if (busy !== 1'b0 || hi !== exp_hi || lo !== exp_lo)
         $display("FAIL flush: busy=%b hi=%h lo=%h required busy=0 hi=%h lo=%h", busy, hi, lo, exp_hi, exp_lo);
      else n_pass++;
      @(negedge clk);
      startE = 1'b0; flushE = 1'b0; hiwrE = 1'b0; lowrE = 1'b1; srcaE = 32'h00001234;
      @(posedge clk); #1;
      exp_lo = 32'h00001234;
      n_checks++;
      if (lo !== exp_lo || hi !== exp_hi)
         $display("FAIL mtlo: hi=%h lo=%h required hi=%h lo=%h", hi, lo, exp_hi, exp_lo);
      else n_pass++;
      @(negedge clk);
      lowrE = 1'b0; hiwrE = 1'b1; srcaE = 32'hCAFE0001;
      @(posedge clk); #1;
      exp_hi = 32'hCAFE0001;
      n_checks++;
      if (hi !== exp_hi || lo !== exp_lo)
         $display("FAIL mthi: hi=%h lo=%h required hi=%h lo=%h", hi, lo, exp_hi, exp_lo);
      else n_pass++;
      @(negedge clk);
      hiwrE = 1'b0;
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      start_op(2'b10, 32'h7FFF1234, 32'h00000077);
      repeat (8) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      sb_q.delete();
      exp_hi = '0;
      exp_lo = '0;
      n_checks++;
      if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0)
         $display("FAIL reset_mid: busy=%b hi=%h lo=%h required 0/0/0", busy, hi, lo);
      else n_pass++;
      @(negedge clk);
      reset = 1'b1;
      start_op(2'b01, 32'h00010001, 32'h0000FFFF);
      wait_result("after_reset", lat_of(2'b01), 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_directed();
      test_flush_mtlo();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have port clk, input, 1, single pipeline clock, rising edge.
REQ-002 SHALL have port reset, input, 1, asynchronous, active-low; asserted (0) clears all state immediately.
REQ-003 SHALL have port startE, input, 1, execute-stage mul/div issue, i.e. hienE & loenE from the controller.
REQ-004 SHALL have port opE, input, 2, operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-005 SHALL have ports srcaE and srcbE, input, 32 each, operand rs and rt respectively.
REQ-006 SHALL have ports hiwrE and lowrE, input, 1 each, mthi/mtlo write strobes, data taken from srcaE.
REQ-007 SHALL have port flushE, input, 1, execute bubble; while high, startE, hiwrE and lowrE are ignored.
REQ-008 SHALL have ports hi and lo, output, 32 each, architectural HI/LO registers.
REQ-009 SHALL have port busy, output, 1, high while an operation is in flight; it is consumed by the hazard unit for stalling.

Function
REQ-010 SHALL implement FSM states IDLE, RUN, FIX; busy = (state != IDLE), combinational from state.
REQ-011 SHALL in IDLE, on a rising edge with startE=1 and flushE=0, latch operand magnitudes, result signs and opE, clear the 5-bit count, and enter RUN.
REQ-012 SHALL in RUN perform one iteration per cycle (shift-add multiply or restoring divide on magnitudes); on the edge where count=31, enter FIX.
REQ-013 SHALL in FIX apply sign correction, write hi/lo on the next edge, and return to IDLE.
REQ-014 SHALL give the following latency: start accepted at edge N, hi/lo updated at edge N+33, busy high for exactly 33 cycles.
REQ-015 SHALL ignore startE, hiwrE and lowrE while busy; hi/lo SHALL hold their prior values until the FIX write.
REQ-016 SHALL in IDLE make hiwrE/lowrE (flushE=0) write srcaE into hi/lo on the edge; if startE is also high, startE wins and the writes are dropped.
REQ-017 SHALL for MULT/MULTU produce the 64-bit product: hi = [63:32], lo = [31:0]; signed uses two's-complement operands.
REQ-018 SHALL for DIV/DIVU produce lo = quotient and hi = remainder; signed quotient sign = sign(a) XOR sign(b), remainder sign = sign(a).
REQ-019 SHALL for divide-by-zero (srcbE=0) produce hi = srcaE and lo = 32'hFFFFFFFF, with full 33-cycle latency.
REQ-020 SHALL for DIV 0x80000000 / 0xFFFFFFFF produce lo = 0x80000000, hi = 0, with no trap.
REQ-021 SHALL latch operands at start; srcaE/srcbE changes during RUN do not affect the result.

Reset
REQ-022 SHALL when reset=0 asynchronously force state = IDLE, count = 0, hi = 0, lo = 0, busy = 0.
REQ-023 SHALL on reset mid-operation discard the in-flight result; HI/LO remain 0 after release.
REQ-024 SHALL after reset release (on the first edge) accept startE normally.

Configuration
REQ-025 SHALL with MULDIV_FAST_MULT_EN defined compute MULT/MULTU with a single-cycle combinational multiplier: IDLE goes to FIX at edge N, hi/lo are written at edge N+1, and busy is high for 1 cycle.
REQ-026 SHALL without MULDIV_FAST_MULT_EN use the iterative 33-cycle multiply; divide timing is identical in both builds.

Verification
REQ-027 SHALL verify MULT 7 x 0xFFFFFFFD: hi=0xFFFFFFFF, lo=0xFFFFFFEB at edge N+33 (N+1 with macro), busy low afterwards.
REQ-028 SHALL verify MULTU 0xFFFFFFFF x 2: hi=0x00000001, lo=0xFFFFFFFE.
REQ-029 SHALL verify DIV 0xFFFFFFF9 / 2: lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 100/0: hi=100, lo=0xFFFFFFFF.
REQ-030 SHALL verify that a second startE and hiwrE issued while busy are ignored, and that the result equals that of the first operation.
REQ-031 SHALL verify that reset=0 at cycle 10 of a DIV gives immediate busy=0, hi=lo=0, and that a new MULTU after release completes correctly.
REQ-032 SHALL verify that startE with flushE=1 leaves busy=0 and hi/lo unchanged; mtlo 0x1234 in IDLE gives lo=0x1234 on the next edge.
